// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity and stop-bit selectors.
// Kept separate so the future receiver can use the same encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        BRK_GUARD = 3'd5
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
    localparam logic STOP_1   = 1'b0;
    localparam logic STOP_2   = 1'b1;

    // Parity bit from the XOR of the transmitted data bits and the odd/even selector.
    function automatic logic parity_bit(input logic data_xor, input logic ohel);
        return data_xor ^ (ohel != PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_engine_if.sv
// Port bundle between the PicoBlaze output side (master) and the UART TX engine (slave).
// The brk signal exists only when UART_TX_BREAK_EN is defined.
interface uart_tx_fifo_engine_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int BAUD_W = 20
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              ld;
    logic [DATA_W-1:0] out_port;
    logic              bit8;
    logic              pen;
    logic              ohel;
    logic              stop2;
    logic [BAUD_W-1:0] baud_rate;
`ifdef UART_TX_BREAK_EN
    logic              brk;
`endif
    logic              tx;
    logic              txrdy;
    logic              tx_busy;
    logic [CNT_W-1:0]  fifo_count;
    logic              overflow;

    modport master (
        output ld, out_port, bit8, pen, ohel, stop2, baud_rate,
`ifdef UART_TX_BREAK_EN
        output brk,
`endif
        input  tx, txrdy, tx_busy, fifo_count, overflow
    );

    modport slave (
        input  ld, out_port, bit8, pen, ohel, stop2, baud_rate,
`ifdef UART_TX_BREAK_EN
        input  brk,
`endif
        output tx, txrdy, tx_busy, fifo_count, overflow
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO for the UART transmitter: DEPTH x DATA_W, same-cycle
// pop frees the slot for a push into a full FIFO.
module uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count_q;
    logic              do_wr;
    logic              do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_rd   = rd && !empty;
    assign do_wr   = wr && (!full || do_rd);
    assign rd_data = mem[rd_ptr];
    assign count   = count_q;

    // NOTE: the storage array has no reset; only pointers and count define validity,
    // so clearing it would cost a reset net per bit for no functional gain.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo_engine.sv
// UART transmitter with TX FIFO: 7/8 data bits, optional odd/even parity, 1/2 stop bits.
// Define UART_TX_BREAK_EN to add the brk port and break/guard-time logic.
module uart_tx_fifo_engine
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int BAUD_W = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_fifo_engine_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    tx_state_t         state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_m1;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_q;
    logic              par_acc;
    logic              bit8_q;
    logic              pen_q;
    logic              ohel_q;
    logic              stop2_q;
    logic              tx_q;
    logic              overflow_q;

    logic              fifo_rd;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;

    logic              line_level;
    logic              idle_level;
    logic              idle_hold;
    logic              bit_done;
    logic              last_data;
    logic              last_stop;

    // A baud_rate of 0 behaves as 1 cycle per bit.
    function automatic logic [BAUD_W-1:0] period_m1(input logic [BAUD_W-1:0] baud);
        return (baud == '0) ? '0 : baud - 1'b1;
    endfunction

    uart_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr      (bus.ld),
        .wr_data (bus.out_port),
        .rd      (fifo_rd),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bit_done  = (baud_cnt == '0);
    assign last_data = (bit_idx == (bit8_q ? 3'd7 : 3'd6));
    assign last_stop = (stop2_q != STOP_2) || bit_idx[0];

`ifdef UART_TX_BREAK_EN
    // Remembers a break seen in IDLE so its release can be followed by the guard bit.
    logic brk_seen;

    always_ff @(posedge clk) begin
        if (reset) begin
            brk_seen <= 1'b0;
        end else if (state == IDLE) begin
            brk_seen <= bus.brk;
        end
    end

    assign idle_hold  = bus.brk || brk_seen;
    assign idle_level = !brk_seen;
`else
    assign idle_hold  = 1'b0;
    assign idle_level = 1'b1;
`endif

    // Pop happens from IDLE, or at the very end of the stop/guard period for back-to-back frames.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        fifo_rd = 1'b0;
        case (state)
            IDLE:      fifo_rd = !fifo_empty && !idle_hold;
            STOP:      fifo_rd = bit_done && last_stop && !fifo_empty;
            BRK_GUARD: fifo_rd = bit_done && !fifo_empty;
            default:   fifo_rd = 1'b0;
        endcase
    end

    always_comb begin
        line_level = 1'b1;
        case (state)
            IDLE:    line_level = idle_level;
            START:   line_level = 1'b0;
            DATA:    line_level = shift_q[0];
            PARITY:  line_level = parity_bit(par_acc, ohel_q);
            default: line_level = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            baud_m1  <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
            par_acc  <= 1'b0;
            bit8_q   <= 1'b0;
            pen_q    <= 1'b0;
            ohel_q   <= 1'b0;
            stop2_q  <= 1'b0;
        end else if (fifo_rd) begin
            // Frame format is frozen here; later input changes wait for the next pop.
            state    <= START;
            shift_q  <= fifo_head[7:0];
            bit8_q   <= bus.bit8;
            pen_q    <= bus.pen;
            ohel_q   <= bus.ohel;
            stop2_q  <= bus.stop2;
            baud_m1  <= period_m1(bus.baud_rate);
            baud_cnt <= period_m1(bus.baud_rate);
            bit_idx  <= '0;
            par_acc  <= 1'b0;
`ifdef UART_TX_BREAK_EN
        end else if (state == IDLE && brk_seen && !bus.brk) begin
            state    <= BRK_GUARD;
            baud_m1  <= period_m1(bus.baud_rate);
            baud_cnt <= period_m1(bus.baud_rate);
`endif
        end else if (state != IDLE) begin
            if (!bit_done) begin
                baud_cnt <= baud_cnt - 1'b1;
            end else begin
                baud_cnt <= baud_m1;
                case (state)
                    START: begin
                        state <= DATA;
                    end
                    DATA: begin
                        par_acc <= par_acc ^ shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (last_data) begin
                            bit_idx <= '0;
                            state   <= pen_q ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    PARITY: begin
                        state <= STOP;
                    end
                    STOP: begin
                        if (last_stop) begin
                            state <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // The line is a register fed by the state decode, so tx trails the state by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            tx_q <= line_level;
            if (bus.ld && fifo_full && !fifo_rd) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.tx         = tx_q;
    assign bus.txrdy      = !fifo_full;
    assign bus.tx_busy    = (state != IDLE) || !fifo_empty;
    assign bus.fifo_count = fifo_count;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo_engine.sv
// Self-checking bench for uart_tx_fifo_engine: directed frames plus random traffic against
// a queue-based reference that expands each popped byte into its expected line waveform.
module tb_uart_tx_fifo_engine;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int BAUD_W = 20;

    logic clk = 1'b0;
    logic reset;
    bit   brk_drv;

    always #5 clk = ~clk;

    uart_tx_fifo_engine_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BAUD_W(BAUD_W)) u_if ();

    uart_tx_fifo_engine #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .BAUD_W (BAUD_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    int n_checks;
    int n_errors;

    // Reference model: queued bytes, expected future line levels, frame time left.
    logic [7:0] mq[$];
    bit         wave[$];
    int         rem;
    bit         m_ovf;
    bit         m_brk_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int bit_period();
        return (u_if.baud_rate == '0) ? 1 : int'(u_if.baud_rate);
    endfunction

    // Append a whole frame to the expected waveform; returns its length in cycles.
    function automatic int build_frame(input logic [7:0] d, input bit b8, input bit p_en,
                                       input bit odd, input bit s2, input int per);
        bit lv[$];
        bit x;
        int n;
        x = 1'b0;
        n = b8 ? 8 : 7;
        lv.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            lv.push_back(d[i]);
            x ^= d[i];
        end
        if (p_en) lv.push_back(odd ? !x : x);
        lv.push_back(1'b1);
        if (s2) lv.push_back(1'b1);
        foreach (lv[i]) repeat (per) wave.push_back(lv[i]);
        return lv.size() * per;
    endfunction

    task automatic model_edge(output bit exp_tx);
        bit was_idle;
        if (reset) begin
            mq.delete();
            wave.delete();
            rem        = 0;
            m_ovf      = 1'b0;
            m_brk_seen = 1'b0;
            exp_tx     = 1'b1;
            return;
        end
        exp_tx   = (wave.size() > 0) ? wave.pop_front() : !m_brk_seen;
        was_idle = (rem == 0);
        if (rem > 0) rem--;
        if (was_idle && brk_drv) begin
            m_brk_seen = 1'b1;
        end else if (was_idle && m_brk_seen) begin
            m_brk_seen = 1'b0;
            rem = bit_period();
            repeat (rem) wave.push_back(1'b1);
        end else if (rem == 0 && mq.size() > 0) begin
            rem = build_frame(mq.pop_front(), u_if.bit8, u_if.pen, u_if.ohel, u_if.stop2, bit_period());
        end
        if (u_if.ld) begin
            if (mq.size() < DEPTH) mq.push_back(u_if.out_port[7:0]);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic step();
        bit exp_tx;
        @(posedge clk);
        model_edge(exp_tx);
        #1;
        check("tx", 32'(u_if.tx), 32'(exp_tx));
        check("fifo_count", 32'(u_if.fifo_count), 32'(mq.size()));
        check("txrdy", 32'(u_if.txrdy), 32'(mq.size() < DEPTH));
        check("tx_busy", 32'(u_if.tx_busy), 32'(rem > 0 || mq.size() > 0));
        check("overflow", 32'(u_if.overflow), 32'(m_ovf));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic ld_byte(input logic [7:0] d);
        u_if.out_port = DATA_W'(d);
        u_if.ld       = 1'b1;
        step();
        u_if.ld       = 1'b0;
    endtask

    task automatic set_cfg(input bit b8, input bit p_en, input bit odd, input bit s2, input int baud);
        u_if.bit8      = b8;
        u_if.pen       = p_en;
        u_if.ohel      = odd;
        u_if.stop2     = s2;
        u_if.baud_rate = BAUD_W'(baud);
    endtask

    task automatic drain(input int max_cycles);
        int k;
        k = 0;
        while ((rem > 0 || mq.size() > 0) && k < max_cycles) begin
            step();
            k++;
        end
        check("drain_idle", 32'(u_if.tx_busy), 32'd0);
        run(3);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rem         = 0;
        m_ovf       = 1'b0;
        m_brk_seen  = 1'b0;
        brk_drv     = 1'b0;
        u_if.ld       = 1'b0;
        u_if.out_port = '0;
`ifdef UART_TX_BREAK_EN
        u_if.brk      = 1'b0;
`endif
        set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 109);

        // Reset state
        reset = 1'b1;
        run(3);
        reset = 1'b0;
        check("rst_tx", 32'(u_if.tx), 32'd1);
        check("rst_count", 32'(u_if.fifo_count), 32'd0);

        // 8N1 0x3A, then 8E1, 8O2 and 7N1 0xC1
        ld_byte(8'h3A);
        drain(3000);
        set_cfg(1'b1, 1'b1, 1'b0, 1'b0, 109);
        ld_byte(8'h3A);
        drain(3000);
        set_cfg(1'b1, 1'b1, 1'b1, 1'b1, 109);
        ld_byte(8'h3A);
        drain(3000);
        set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 109);
        ld_byte(8'hC1);
        drain(3000);

        // Back-to-back pushes past full: one drop, sticky overflow, gapless frames
        set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 3);
        for (int i = 0; i < DEPTH + 2; i++) begin
            u_if.out_port = DATA_W'(i * 37 + 5);
            u_if.ld       = 1'b1;
            step();
            if (i == DEPTH) check("t3_txrdy_full", 32'(u_if.txrdy), 32'd0);
        end
        u_if.ld = 1'b0;
        check("t3_overflow", 32'(u_if.overflow), 32'd1);
        drain(5000);
        check("t3_overflow_sticky", 32'(u_if.overflow), 32'd1);

        // Reset in the middle of the data bits with a loaded FIFO and overflow set
        set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 20);
        for (int i = 0; i < DEPTH + 2; i++) begin
            u_if.out_port = DATA_W'(8'hF0 ^ i);
            u_if.ld       = 1'b1;
            step();
        end
        u_if.ld = 1'b0;
        run(60);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t4_tx", 32'(u_if.tx), 32'd1);
        check("t4_count", 32'(u_if.fifo_count), 32'd0);
        check("t4_overflow", 32'(u_if.overflow), 32'd0);
        run(300);

        // Format inputs changed mid-frame only affect the following frame
        set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 5);
        ld_byte(8'hA5);
        ld_byte(8'h5A);
        run(12);
        set_cfg(1'b0, 1'b1, 1'b1, 1'b1, 5);
        drain(1000);

`ifdef UART_TX_BREAK_EN
        // Break held 500 cycles with two bytes queued
        set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 109);
        brk_drv  = 1'b1;
        u_if.brk = 1'b1;
        step();
        ld_byte(8'h55);
        ld_byte(8'h0F);
        run(497);
        brk_drv  = 1'b0;
        u_if.brk = 1'b0;
        drain(4000);
`endif

        // Random traffic with format changes every cycle and one reset pulse
        u_if.baud_rate = BAUD_W'(2);
        for (int i = 0; i < 3000; i++) begin
            u_if.ld       = ($urandom_range(0, 3) == 0);
            u_if.out_port = DATA_W'($urandom);
            u_if.bit8     = 1'($urandom_range(0, 1));
            u_if.pen      = 1'($urandom_range(0, 1));
            u_if.ohel     = 1'($urandom_range(0, 1));
            u_if.stop2    = 1'($urandom_range(0, 1));
            if (i % 97 == 0) u_if.baud_rate = BAUD_W'($urandom_range(0, 4));
            reset = (i == 1500);
            step();
        end
        reset   = 1'b0;
        u_if.ld = 1'b0;
        drain(20000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
